// File: rtl/fir3_pkg.sv
// Shared constants and types for the three-parallel FIR stream controller.
package fir3_pkg;

    localparam int unsigned TAPS   = 102;
    localparam int unsigned PAR    = 3;
    localparam int unsigned DEF_DW = 16;
    localparam int unsigned DEF_OW = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN
    } fir3_state_e;

endpackage

// File: rtl/fir3_stream_ctrl_if.sv
// Valid/ready stream bundle; master drives valid/data, slave drives ready.
interface fir3_stream_ctrl_if #(
    parameter int unsigned W = 16
);
    logic                valid;
    logic signed [W-1:0] data;
    logic                ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fir3_out_serializer.sv
// Captures one block of filter results and replays them in sample order over valid/ready.
module fir3_out_serializer
    import fir3_pkg::*;
#(
    parameter int unsigned OW = DEF_OW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [1:0]           len,
    input  logic signed [OW-1:0] din1,
    input  logic signed [OW-1:0] din2,
    input  logic signed [OW-1:0] din3,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_data,
    input  logic                 out_ready,
    output logic                 done
);

    logic signed [OW-1:0] cap [PAR];
    logic [1:0]           blk_len;
    logic [1:0]           rd_idx;
    logic                 last;

    assign last = (rd_idx == blk_len - 2'd1);
    assign done = out_valid && out_ready && last;

    always_comb begin
        out_data = '0;
        case (rd_idx)
            2'd0:    out_data = cap[0];
            2'd1:    out_data = cap[1];
            2'd2:    out_data = cap[2];
            default: out_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PAR; i++) begin
                cap[i] <= '0;
            end
            blk_len   <= 2'd0;
            rd_idx    <= 2'd0;
            out_valid <= 1'b0;
        end else if (load) begin
            cap[0]    <= din1;
            cap[1]    <= din2;
            cap[2]    <= din3;
            blk_len   <= len;
            rd_idx    <= 2'd0;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            // Rewind on the last beat so the index never points past the buffer.
            if (last) begin
                out_valid <= 1'b0;
                rd_idx    <= 2'd0;
            end else begin
                rd_idx <= rd_idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/fir3_stream_ctrl.sv
// Packs serial samples into 3-sample blocks, strobes the enable-gated FIR, and serializes results.
module fir3_stream_ctrl
    import fir3_pkg::*;
#(
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned OW      = DEF_OW,
    parameter int unsigned FIR_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fir3_stream_ctrl_if.slave    src,
    input  logic                 flush,
    output logic                 fir_en,
    output logic signed [DW-1:0] fir_din1,
    output logic signed [DW-1:0] fir_din2,
    output logic signed [DW-1:0] fir_din3,
    input  logic signed [OW-1:0] fir_dout1,
    input  logic signed [OW-1:0] fir_dout2,
    input  logic signed [OW-1:0] fir_dout3,
    fir3_stream_ctrl_if.master   snk,
    output logic                 busy,
    output logic [31:0]          blk_count
);

    localparam int unsigned CW = $clog2(FIR_LAT) + 1;

    logic signed [DW-1:0] slot [PAR];
    logic [1:0]           wr_idx;
    logic [1:0]           wr_next;
    logic [1:0]           blk_len;
    logic [1:0]           iss_len;
    logic                 blk_full;
    logic                 hs;
    logic                 flush_ok;

    fir3_state_e          state;
    logic [CW-1:0]        wait_cnt;
    logic                 wait_done;
    logic                 start_issue;
    logic                 load;
    logic                 ser_done;

    assign src.ready = !blk_full;
    assign hs        = src.valid && !blk_full;
    // A same-cycle flush sees the slot count after this cycle's write.
    assign wr_next   = hs ? wr_idx + 2'd1 : wr_idx;
    assign flush_ok  = flush && !blk_full && (wr_next == 2'd1 || wr_next == 2'd2);

    assign fir_din1 = slot[0];
    assign fir_din2 = slot[1];
    assign fir_din3 = slot[2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PAR; i++) begin
                slot[i] <= '0;
            end
            wr_idx   <= 2'd0;
            blk_len  <= 2'd0;
            blk_full <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                blk_full <= 1'b0;
            end
            if (hs) begin
                slot[wr_idx] <= src.data;
            end
            if (hs && wr_idx == 2'd2) begin
                blk_full <= 1'b1;
                blk_len  <= 2'd3;
                wr_idx   <= 2'd0;
            end else if (flush_ok) begin
                for (int i = 0; i < PAR; i++) begin
                    if (i >= int'(wr_next)) begin
                        slot[i] <= '0;
                    end
                end
                blk_full <= 1'b1;
                blk_len  <= wr_next;
                wr_idx   <= 2'd0;
            end else if (hs) begin
                wr_idx <= wr_idx + 2'd1;
            end
        end
    end

    assign wait_done   = (wait_cnt == CW'(FIR_LAT - 1));
    assign load        = (state == WAIT) && wait_done;
    // Issuing straight out of the final drain beat keeps the steady-state rate at 5 cycles/block.
    assign start_issue = blk_full && ((state == IDLE) || (state == DRAIN && ser_done));
    assign busy        = blk_full || (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            fir_en    <= 1'b0;
            blk_count <= 32'd0;
            wait_cnt  <= '0;
            iss_len   <= 2'd0;
        end else begin
            fir_en <= start_issue;
            if (start_issue) begin
                state     <= ISSUE;
                blk_count <= blk_count + 32'd1;
                iss_len   <= blk_len;
            end else begin
                unique case (state)
                    IDLE: state <= IDLE;
                    ISSUE: begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                    WAIT: begin
                        if (wait_done) begin
                            state <= DRAIN;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (ser_done) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    fir3_out_serializer #(
        .OW (OW)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .len       (iss_len),
        .din1      (fir_dout1),
        .din2      (fir_dout2),
        .din3      (fir_dout3),
        .out_valid (snk.valid),
        .out_data  (snk.data),
        .out_ready (snk.ready),
        .done      (ser_done)
    );

endmodule

// File: tb/tb_fir3_stream_ctrl.sv
// Directed bench for fir3_stream_ctrl with a one-cycle pass-through filter stub.
module tb_fir3_stream_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned OW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic fir_en;
    logic signed [DW-1:0] fir_din1, fir_din2, fir_din3;
    logic signed [OW-1:0] fir_dout1 = '0, fir_dout2 = '0, fir_dout3 = '0;
    logic busy;
    logic [31:0] blk_count;

    fir3_stream_ctrl_if #(.W(DW)) src_if ();
    fir3_stream_ctrl_if #(.W(OW)) snk_if ();

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int fir_pulses = 0;
    int double_en = 0;
    logic fir_en_prev = 1'b0;
    logic [47:0] din_q [$];
    logic [63:0] out_q [$];
    int en_cyc [$];

    fir3_stream_ctrl #(
        .DW      (DW),
        .OW      (OW),
        .FIR_LAT (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src       (src_if),
        .flush     (flush),
        .fir_en    (fir_en),
        .fir_din1  (fir_din1),
        .fir_din2  (fir_din2),
        .fir_din3  (fir_din3),
        .fir_dout1 (fir_dout1),
        .fir_dout2 (fir_dout2),
        .fir_dout3 (fir_dout3),
        .snk       (snk_if),
        .busy      (busy),
        .blk_count (blk_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stub filter: sign-extended pass-through, registered on fir_en, never reset.
    always @(posedge clk) begin
        if (fir_en) begin
            fir_dout1 <= {{(OW-DW){fir_din1[DW-1]}}, fir_din1};
            fir_dout2 <= {{(OW-DW){fir_din2[DW-1]}}, fir_din2};
            fir_dout3 <= {{(OW-DW){fir_din3[DW-1]}}, fir_din3};
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (snk_if.valid && snk_if.ready) out_q.push_back(snk_if.data);
            if (fir_en) begin
                fir_pulses++;
                din_q.push_back({fir_din1, fir_din2, fir_din3});
                en_cyc.push_back(cyc);
            end
            if (fir_en && fir_en_prev) double_en++;
        end
        fir_en_prev = fir_en;
    end

    function automatic logic [63:0] sx(input int v);
        return 64'(v);
    endfunction

    function automatic logic [47:0] pk(input int a, input int b, input int c);
        return {16'(a), 16'(b), 16'(c)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        din_q.delete();
        out_q.delete();
        en_cyc.delete();
    endtask

    task automatic send_sample(input int v);
        bit ok;
        bit done;
        done = 1'b0;
        src_if.valid = 1'b1;
        src_if.data  = 16'(v);
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            ok = src_if.ready;
            tick();
            done = ok;
        end
        src_if.valid = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: sample %0d accepted=0 required=1", v);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || snk_if.valid) && t < 400) begin
            tick();
            t++;
        end
        if (busy || snk_if.valid) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: busy=%0b out_valid=%0b required 0/0", busy, snk_if.valid);
        end
        tick();
    endtask

    task automatic wait_out_valid(output int n);
        n = 0;
        while (!snk_if.valid && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({src_if.ready, fir_en, snk_if.valid, busy} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_ctrl: rdy/en/vld/busy=%b required 1000",
                     {src_if.ready, fir_en, snk_if.valid, busy});
        end
        vectors++;
        if ({fir_din1, fir_din2, fir_din3} !== 48'd0 || snk_if.data !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_data: din=%h out=%h required 0", {fir_din1, fir_din2, fir_din3},
                     snk_if.data);
        end
        vectors++;
        if (blk_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_count: blk_count=%0d required 0", blk_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        int exp_v [3] = '{1, 2, 3};
        clear_logs();
        send_sample(1);
        send_sample(2);
        send_sample(3);
        wait_out_valid(lat);
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL basic_latency: cycles=%0d required 3", lat);
        end
        wait_idle();
        vectors++;
        if (din_q.size() !== 1 || din_q[0] !== pk(1, 2, 3)) begin
            miscompares++;
            $display("FAIL basic_din: pulses=%0d din=%h required 1/%h", din_q.size(),
                     (din_q.size() > 0) ? din_q[0] : 48'd0, pk(1, 2, 3));
        end
        vectors++;
        if (out_q.size() !== 3) begin
            miscompares++;
            $display("FAIL basic_count: outputs=%0d required 3", out_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (out_q[i] !== sx(exp_v[i])) begin
                    miscompares++;
                    $display("FAIL basic_out%0d: got %h required %h", i, out_q[i], sx(exp_v[i]));
                end
            end
        end
        vectors++;
        if (blk_count !== 32'd1) begin
            miscompares++;
            $display("FAIL basic_blk_count: got %0d required 1", blk_count);
        end
    endtask

    task automatic test_ramp();
        int bad_data;
        int bad_gap;
        clear_logs();
        for (int i = 0; i < 300; i++) send_sample(100 + i);
        wait_idle();
        vectors++;
        if (en_cyc.size() !== 100) begin
            miscompares++;
            $display("FAIL ramp_pulses: got %0d required 100", en_cyc.size());
        end
        vectors++;
        if (out_q.size() !== 300) begin
            miscompares++;
            $display("FAIL ramp_count: outputs=%0d required 300", out_q.size());
        end else begin
            bad_data = 0;
            for (int i = 0; i < 300; i++) if (out_q[i] !== sx(100 + i)) bad_data++;
            vectors++;
            if (bad_data !== 0) begin
                miscompares++;
                $display("FAIL ramp_order: wrong outputs=%0d required 0", bad_data);
            end
        end
        bad_gap = 0;
        for (int i = 2; i < en_cyc.size(); i++) if (en_cyc[i] - en_cyc[i-1] != 5) bad_gap++;
        vectors++;
        if (bad_gap !== 0) begin
            miscompares++;
            $display("FAIL ramp_rate: block gaps not 5 cycles=%0d required 0", bad_gap);
        end
        vectors++;
        if (blk_count !== 32'd101) begin
            miscompares++;
            $display("FAIL ramp_blk_count: got %0d required 101", blk_count);
        end
    endtask

    task automatic test_flush();
        int p0;
        clear_logs();
        send_sample(-5);
        send_sample(7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_idle();
        vectors++;
        if (din_q.size() !== 1 || din_q[0] !== pk(-5, 7, 0)) begin
            miscompares++;
            $display("FAIL flush_din: pulses=%0d din=%h required 1/%h", din_q.size(),
                     (din_q.size() > 0) ? din_q[0] : 48'd0, pk(-5, 7, 0));
        end
        vectors++;
        if (out_q.size() !== 2 || out_q[0] !== sx(-5) || out_q[1] !== sx(7)) begin
            miscompares++;
            $display("FAIL flush_out: n=%0d first=%h required 2/%h then %h", out_q.size(),
                     (out_q.size() > 0) ? out_q[0] : 64'd0, sx(-5), sx(7));
        end
        clear_logs();
        p0 = fir_pulses;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (8) tick();
        vectors++;
        if (fir_pulses !== p0 || out_q.size() !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_empty: pulses=%0d outputs=%0d busy=%0b required 0/0/0",
                     fir_pulses - p0, out_q.size(), busy);
        end
        vectors++;
        if (blk_count !== 32'd102) begin
            miscompares++;
            $display("FAIL flush_blk_count: got %0d required 102", blk_count);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int p0;
        logic [63:0] hold;
        int exp_v [6] = '{11, 22, 33, 44, 55, 66};
        clear_logs();
        snk_if.ready = 1'b1;
        send_sample(11);
        send_sample(22);
        send_sample(33);
        wait_out_valid(n);
        tick();
        snk_if.ready = 1'b0;
        hold = snk_if.data;
        p0 = fir_pulses;
        vectors++;
        if (hold !== sx(22)) begin
            miscompares++;
            $display("FAIL bp_second: got %h required %h", hold, sx(22));
        end
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    tick();
                    vectors++;
                    if (snk_if.valid !== 1'b1 || snk_if.data !== hold) begin
                        miscompares++;
                        $display("FAIL bp_stable%0d: vld=%0b data=%h required 1/%h", i,
                                 snk_if.valid, snk_if.data, hold);
                    end
                end
            end
            begin
                send_sample(44);
                send_sample(55);
                send_sample(66);
                vectors++;
                if (src_if.ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_in_ready: got %0b required 0", src_if.ready);
                end
            end
        join
        vectors++;
        if (fir_pulses !== p0) begin
            miscompares++;
            $display("FAIL bp_no_issue: pulses during stall=%0d required 0", fir_pulses - p0);
        end
        snk_if.ready = 1'b1;
        wait_idle();
        vectors++;
        if (out_q.size() !== 6) begin
            miscompares++;
            $display("FAIL bp_count: outputs=%0d required 6", out_q.size());
        end else begin
            n = 0;
            for (int i = 0; i < 6; i++) if (out_q[i] !== sx(exp_v[i])) n++;
            vectors++;
            if (n !== 0) begin
                miscompares++;
                $display("FAIL bp_order: wrong outputs=%0d required 0", n);
            end
        end
        vectors++;
        if (blk_count !== 32'd104) begin
            miscompares++;
            $display("FAIL bp_blk_count: got %0d required 104", blk_count);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int exp_v [3] = '{9, 8, 7};
        for (int pass = 0; pass < 2; pass++) begin
            send_sample(101 + 3 * pass);
            send_sample(102 + 3 * pass);
            send_sample(103 + 3 * pass);
            if (pass == 0) begin
                tick();
                tick();
            end else begin
                wait_out_valid(n);
            end
            rst_n = 1'b0;
            tick();
            vectors++;
            if ({src_if.ready, fir_en, snk_if.valid, busy} !== 4'b1000 ||
                {fir_din1, fir_din2, fir_din3} !== 48'd0 || snk_if.data !== 64'd0 ||
                blk_count !== 32'd0) begin
                miscompares++;
                $display("FAIL rst_mid%0d: rdy/en/vld/busy=%b din=%h out=%h cnt=%0d required 1000/0",
                         pass, {src_if.ready, fir_en, snk_if.valid, busy},
                         {fir_din1, fir_din2, fir_din3}, snk_if.data, blk_count);
            end
            rst_n = 1'b1;
            tick();
        end
        clear_logs();
        send_sample(9);
        send_sample(8);
        send_sample(7);
        wait_idle();
        vectors++;
        if (out_q.size() !== 3) begin
            miscompares++;
            $display("FAIL rst_after_count: outputs=%0d required 3", out_q.size());
        end else begin
            n = 0;
            for (int i = 0; i < 3; i++) if (out_q[i] !== sx(exp_v[i])) n++;
            vectors++;
            if (n !== 0) begin
                miscompares++;
                $display("FAIL rst_after_order: wrong outputs=%0d required 0", n);
            end
        end
        vectors++;
        if (blk_count !== 32'd1) begin
            miscompares++;
            $display("FAIL rst_after_blk_count: got %0d required 1", blk_count);
        end
    endtask

    task automatic test_flush_same_cycle();
        clear_logs();
        send_sample(21);
        src_if.valid = 1'b1;
        src_if.data  = 16'(22);
        flush        = 1'b1;
        tick();
        src_if.valid = 1'b0;
        flush        = 1'b0;
        wait_idle();
        vectors++;
        if (din_q.size() !== 1 || din_q[0] !== pk(21, 22, 0)) begin
            miscompares++;
            $display("FAIL same_cycle_din: pulses=%0d din=%h required 1/%h", din_q.size(),
                     (din_q.size() > 0) ? din_q[0] : 48'd0, pk(21, 22, 0));
        end
        vectors++;
        if (out_q.size() !== 2 || out_q[0] !== sx(21) || out_q[1] !== sx(22)) begin
            miscompares++;
            $display("FAIL same_cycle_out: n=%0d first=%h required 2/%h then %h", out_q.size(),
                     (out_q.size() > 0) ? out_q[0] : 64'd0, sx(21), sx(22));
        end
    endtask

    initial begin
        src_if.valid = 1'b0;
        src_if.data  = '0;
        snk_if.ready = 1'b1;
        test_reset();
        test_basic();
        test_ramp();
        test_flush();
        test_backpressure();
        test_reset_mid();
        test_flush_same_cycle();
        vectors++;
        if (double_en !== 0) begin
            miscompares++;
            $display("FAIL fir_en_back_to_back: occurrences=%0d required 0", double_en);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
